// File: rtl/program_sequencer_pkg.sv
// Shared sequencer definitions: flow opcodes, FSM states, two-word opcode.
// Imported by the sequencer, its stack and the instruction decoder.
package program_sequencer_pkg;

  localparam logic [3:0] TWO_WORD_OPC = 4'hF;

  typedef enum logic [2:0] {
    SEQ_NEXT = 3'd0,
    SEQ_BR   = 3'd1,
    SEQ_CALL = 3'd2,
    SEQ_RET  = 3'd3,
    SEQ_PUSH = 3'd4,
    SEQ_POP  = 3'd5,
    SEQ_CALA = 3'd6,
    SEQ_RSVD = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_FETCH  = 2'd1,
    S_FETCH2 = 2'd2,
    S_EXEC   = 2'd3
  } state_e;

  function automatic logic is_two_word(input logic [3:0] opc);
    return opc == TWO_WORD_OPC;
  endfunction

endpackage

// File: rtl/hw_stack.sv
// Shift-register hardware stack: push shifts down (bottom lost), pop shifts up
// (bottom duplicates). Ports: clk, reset (async low), push, pop, din, top, level.
module hw_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] s [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      level <= '0;
    end else if (push) begin
      s[0] <= din;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      if (level != FULL) level <= level + 1'b1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH-1; i++) s[i] <= s[i+1];
      if (level != '0) level <= level - 1'b1;
    end
  end

  assign top = s[0];

endmodule

// File: rtl/program_sequencer.sv
// Instruction front end: PC, 1/2-word fetch FSM, flow control, hw stack.
// Ports: clk/reset, rom_addr/rom_data, stall, seq_op/cond/acc_lo, instr/operand/instr_valid, stack_top/stack_level.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic [PC_WIDTH-1:0]                rom_addr,
  input  logic [INSTR_WIDTH-1:0]             rom_data,
  input  logic                               stall,
  input  logic [2:0]                         seq_op,
  input  logic                               cond,
  input  logic [PC_WIDTH-1:0]                acc_lo,
  output logic [INSTR_WIDTH-1:0]             instr,
  output logic [INSTR_WIDTH-1:0]             operand,
  output logic                               instr_valid,
  output logic [PC_WIDTH-1:0]                stack_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [INSTR_WIDTH-1:0]  opnd_q, opnd_d;
  logic                    push, pop;
  logic [PC_WIDTH-1:0]     push_val;
  seq_op_e                 op;

  assign op = seq_op_e'(seq_op);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    opnd_d   = opnd_q;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = pc_q;
    if (!stall) begin
      unique case (state_q)
        S_RESET: state_d = S_FETCH;
        S_FETCH: begin
          instr_d = rom_data;
          pc_d    = pc_q + 1'b1;
          state_d = is_two_word(rom_data[INSTR_WIDTH-1 -: 4])
                    ? S_FETCH2 : S_EXEC;
        end
        S_FETCH2: begin
          opnd_d  = rom_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          unique case (op)
            SEQ_BR:
              if (cond) pc_d = opnd_q[PC_WIDTH-1:0];
            SEQ_CALL: begin
              push = 1'b1;
              pc_d = opnd_q[PC_WIDTH-1:0];
            end
            SEQ_RET: begin
              pop  = 1'b1;
              pc_d = stack_top;
            end
            SEQ_PUSH: begin
              push     = 1'b1;
              push_val = acc_lo;
            end
            SEQ_POP: pop = 1'b1;
            SEQ_CALA: begin
              push = 1'b1;
              pc_d = acc_lo;
            end
            default: ;
          endcase
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      pc_q    <= '0;
      instr_q <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opnd_q  <= opnd_d;
    end
  end

  hw_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_val),
    .top   (stack_top),
    .level (stack_level)
  );

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign operand     = opnd_q;
  assign instr_valid = (state_q == S_EXEC);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed corners, stack table,
// and randomized programs checked against an instruction-level model.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        cond = 1'b0;
  logic [2:0]  seq_op = 3'd0;
  logic [11:0] acc_lo = 12'd0;
  logic [11:0] rom_addr, stack_top;
  logic [15:0] rom_data, instr, operand;
  logic [2:0]  stack_level;
  logic        instr_valid;

  logic [15:0] rom [4096];
  int n_chk = 0;
  int n_fail = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .stall       (stall),
    .seq_op      (seq_op),
    .cond        (cond),
    .acc_lo      (acc_lo),
    .instr       (instr),
    .operand     (operand),
    .instr_valid (instr_valid),
    .stack_top   (stack_top),
    .stack_level (stack_level)
  );

  logic [11:0] m_pc;
  logic [15:0] m_opnd;
  logic [11:0] m_stk [$];
  int          m_lvl;
  logic [11:0] o_next;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_push(input logic [11:0] v);
    m_stk.push_front(v);
    void'(m_stk.pop_back());
    m_lvl = (m_lvl < 4) ? m_lvl + 1 : 4;
  endtask

  task automatic m_pop();
    logic [11:0] b;
    b = m_stk[3];
    void'(m_stk.pop_front());
    m_stk.push_back(b);
    m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    seq_op = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_pc = 12'd0;
    m_opnd = 16'd0;
    m_stk = {12'd0, 12'd0, 12'd0, 12'd0};
    m_lvl = 0;
  endtask

  // Runs one instruction from S_FETCH to the following S_FETCH.
  task automatic exec_one(input logic [2:0] op, input logic c,
                          input logic [11:0] a, input bit st_en,
                          output logic [11:0] x_top, output int x_lvl);
    logic [15:0] e_ins;
    bit two;
    int cyc;
    int n;
    x_top = 12'd0;
    x_lvl = 0;
    chk("fetch_addr", rom_addr, m_pc);
    e_ins = rom[m_pc];
    m_pc = m_pc + 12'd1;
    two = (e_ins[15:12] == 4'hF);
    if (two) begin
      m_opnd = rom[m_pc];
      m_pc = m_pc + 12'd1;
    end
    cyc = 0;
    while (!instr_valid && cyc < 16) begin
      stall = st_en && ($urandom_range(3) == 0);
      seq_op = 3'($urandom);
      cond = 1'($urandom);
      acc_lo = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("exec_reached", instr_valid, 1);
    if (!instr_valid) return;
    if (!st_en) chk("latency", cyc, two ? 2 : 1);
    chk("instr", instr, e_ins);
    chk("operand", operand, m_opnd);
    chk("exec_top", stack_top, m_stk[0]);
    chk("exec_level", stack_level, m_lvl);
    chk("exec_addr", rom_addr, m_pc);
    x_top = stack_top;
    x_lvl = int'(stack_level);
    seq_op = op;
    cond = c;
    acc_lo = a;
    n = st_en ? $urandom_range(2) : 0;
    repeat (n) begin
      stall = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_level", stack_level, m_lvl);
    end
    stall = 1'b0;
    @(posedge clk);
    case (op)
      3'd1: if (c) m_pc = m_opnd[11:0];
      3'd2: begin m_push(m_pc); m_pc = m_opnd[11:0]; end
      3'd3: begin m_pc = m_stk[0]; m_pop(); end
      3'd4: m_push(a);
      3'd5: m_pop();
      3'd6: begin m_push(m_pc); m_pc = a; end
      default: ;
    endcase
    @(negedge clk);
    chk("next_addr", rom_addr, m_pc);
    chk("valid_low", instr_valid, 0);
    chk("after_top", stack_top, m_stk[0]);
    chk("after_level", stack_level, m_lvl);
    o_next = rom_addr;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] acc;
    logic [11:0] top;
    int          lvl;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] xt;
    int xl;
    logic [15:0] w;

    tbl[0]  = '{3'd4, 12'd1, 12'd0, 0};
    tbl[1]  = '{3'd4, 12'd2, 12'd1, 1};
    tbl[2]  = '{3'd4, 12'd3, 12'd2, 2};
    tbl[3]  = '{3'd4, 12'd4, 12'd3, 3};
    tbl[4]  = '{3'd4, 12'd5, 12'd4, 4};
    tbl[5]  = '{3'd5, 12'd0, 12'd5, 4};
    tbl[6]  = '{3'd5, 12'd0, 12'd4, 3};
    tbl[7]  = '{3'd5, 12'd0, 12'd3, 2};
    tbl[8]  = '{3'd5, 12'd0, 12'd2, 1};
    tbl[9]  = '{3'd5, 12'd0, 12'd2, 0};
    tbl[10] = '{3'd0, 12'd0, 12'd2, 0};

    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1234;
    rom[1] = 16'h2345;
    rom[2] = 16'h3456;
    rom[3] = 16'hF900;
    rom[4] = 16'h0020;
    rom[5] = 16'hF111;
    rom[6] = 16'h0010;
    rom[16'h10] = 16'hF000;
    rom[16'h11] = 16'h0100;
    rom[16'h12] = 16'hF000;
    rom[16'h13] = 16'h0FFF;

    // reset state and async reset out of S_EXEC
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_operand", operand, 0);
    chk("rst_level", stack_level, 0);
    chk("rst_top", stack_top, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t1_exec_valid", instr_valid, 1);
    seq_op = 3'd4;
    acc_lo = 12'h5A5;
    reset = 1'b0;
    #1;
    chk("t1_async_valid", instr_valid, 0);
    chk("t1_async_addr", rom_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("t1_edge1_valid", instr_valid, 0);
    @(posedge clk);
    #1 chk("t1_edge2_valid", instr_valid, 1);
    chk("t1_edge2_instr", instr, 16'h1234);
    chk("t1_no_replay", stack_level, 0);
    @(negedge clk);
    seq_op = 3'd0;
    @(posedge clk);
    @(negedge clk);

    // sequential fetch, then taken branch
    do_reset();
    for (int i = 0; i < 3; i++) exec_one(3'd0, 1'b0, 12'd0, 1'b0, xt, xl);
    exec_one(3'd1, 1'b1, 12'd0, 1'b0, xt, xl);
    chk("t3_operand", operand, 16'h0020);
    chk("t3_br_taken", o_next, 12'h020);

    // not-taken branch, call and return
    do_reset();
    for (int i = 0; i < 3; i++) exec_one(3'd0, 1'b0, 12'd0, 1'b0, xt, xl);
    exec_one(3'd1, 1'b0, 12'd0, 1'b0, xt, xl);
    chk("t3_br_not_taken", o_next, 12'h005);
    exec_one(3'd1, 1'b1, 12'd0, 1'b0, xt, xl);
    chk("t4_goto_010", o_next, 12'h010);
    exec_one(3'd2, 1'b0, 12'd0, 1'b0, xt, xl);
    chk("t4_call_addr", o_next, 12'h100);
    chk("t4_call_top", stack_top, 12'h012);
    chk("t4_call_level", stack_level, 1);
    exec_one(3'd3, 1'b0, 12'd0, 1'b0, xt, xl);
    chk("t4_ret_addr", o_next, 12'h012);
    chk("t4_ret_level", stack_level, 0);

    // pc wrap, then stall inside S_FETCH2
    exec_one(3'd1, 1'b1, 12'd0, 1'b0, xt, xl);
    chk("t6_goto_fff", o_next, 12'hFFF);
    exec_one(3'd0, 1'b0, 12'd0, 1'b0, xt, xl);
    chk("t6_wrap", o_next, 12'h000);
    rom[0] = 16'hF123;
    rom[1] = 16'hABCD;
    @(posedge clk);
    @(negedge clk);
    chk("t6_f2_instr", instr, 16'hF123);
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_stall_operand", operand, 16'h0FFF);
      chk("t6_stall_pc", rom_addr, 12'h001);
      chk("t6_stall_valid", instr_valid, 0);
    end
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_operand", operand, 16'hABCD);
    chk("t6_valid", instr_valid, 1);
    chk("t6_pc", rom_addr, 12'h002);
    seq_op = 3'd0;
    @(posedge clk);
    @(negedge clk);

    // stack overflow / underflow table
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      exec_one(tbl[i].op, 1'b0, tbl[i].acc, 1'b0, xt, xl);
      chk("tbl_top", xt, tbl[i].top);
      chk("tbl_level", xl, tbl[i].lvl);
    end

    // randomized programs with random stalls
    for (int i = 0; i < 4096; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) == 0) w[15:12] = 4'hF;
      rom[i] = w;
    end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      exec_one(3'($urandom), 1'($urandom), 12'($urandom), 1'b1, xt, xl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
